// File: rtl/reg_file_multiport_pkg.sv
// Shared types for the multiport register file.
// Holds the clear-sequencer state encoding.
package reg_file_multiport_pkg;

  typedef enum logic {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_e;

endpackage

// File: rtl/reg_file_multiport_clear_seq.sv
// Clear sequencer: walks every entry once, writing zero.
// Entered on reset or on a clear request while idle.
module reg_file_multiport_clear_seq
  import reg_file_multiport_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_req,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST = {ADDR_W{1'b1}};

  rf_state_e         state, state_d;
  logic [ADDR_W-1:0] ptr, ptr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RF_CLEAR;
      ptr   <= '0;
    end else begin
      state <= state_d;
      ptr   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    unique case (state)
      RF_IDLE: begin
        if (clear_req) begin
          state_d = RF_CLEAR;
          ptr_d   = '0;
        end
      end
      RF_CLEAR: begin
        ptr_d = ptr + 1'b1;
        if (ptr == LAST) state_d = RF_IDLE;
      end
      default: state_d = RF_CLEAR;
    endcase
  end

  assign clr_we   = (state == RF_CLEAR);
  assign busy     = clr_we;
  assign clr_addr = ptr;

endmodule

// File: rtl/reg_file_multiport.sv
// Parametrised register file: N registered read ports,
// one write port, bypass, optional zero register, clear sweep.
module reg_file_multiport
  import reg_file_multiport_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear_req,
  output logic                     busy,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_valid,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              wr_live;
  logic              wr_ok;

  reg_file_multiport_clear_seq #(
    .ADDR_W(ADDR_W)
  ) u_clear_seq (
    .clk      (clk),
    .rst      (rst),
    .clear_req(clear_req),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // A user write only lands when idle and no clear is starting.
  assign wr_live = wr_en && !busy && !clear_req;
  assign wr_ok   = wr_live && !(ZERO_REG && wr_addr == '0);

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] val;
    logic [DATA_W-1:0] data_q;
    logic              valid_q;

    assign addr = rd_addr[p*ADDR_W +: ADDR_W];

    always_comb begin
      val = mem[addr];
      if (ZERO_REG && addr == '0) begin
        val = '0;
      end else if (BYPASS && wr_live && wr_addr == addr) begin
        val = wr_data;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else if (busy || !rd_en[p]) begin
        valid_q <= 1'b0;
      end else begin
        data_q  <= val;
        valid_q <= 1'b1;
      end
    end

    assign rd_data[p*DATA_W +: DATA_W] = data_q;
    assign rd_valid[p]                 = valid_q;
  end

endmodule

// File: tb/tb_reg_file_multiport.sv
// Directed self-checking bench for reg_file_multiport
// with default parameters (32x8, two read ports).
module tb_reg_file_multiport;

  logic        clk;
  logic        rst;
  logic        clear_req;
  logic        busy;
  logic [1:0]  rd_en;
  logic [9:0]  rd_addr;
  logic [15:0] rd_data;
  logic [1:0]  rd_valid;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [7:0]  wr_data;

  int vectors;
  int fails;

  reg_file_multiport dut (
    .clk      (clk),
    .rst      (rst),
    .clear_req(clear_req),
    .busy     (busy),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    clear_req = 1'b0;
    rd_en     = 2'b00;
    rd_addr   = '0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
  endtask

  // Counts cycles until busy drops; reads are requested throughout
  // and must never come back valid.
  task automatic sweep(input string tag, output int n);
    bit bad_valid;
    n = 0;
    bad_valid = 1'b0;
    rd_en   = 2'b11;
    rd_addr = {5'd9, 5'd7};
    while (busy && n < 100) begin
      step();
      n++;
      if (rd_valid !== 2'b00) bad_valid = 1'b1;
    end
    rd_en = 2'b00;
    check({tag, "_len"}, n, 32);
    check({tag, "_novalid"}, {31'd0, bad_valid}, 0);
  endtask

  task automatic read_all_zero(input string tag);
    int bad;
    bad = 0;
    for (int a = 0; a < 32; a++) begin
      rd_en   = 2'b11;
      rd_addr = {5'(31 - a), 5'(a)};
      step();
      if (rd_data !== 16'h0000 || rd_valid !== 2'b11) bad++;
    end
    rd_en = 2'b00;
    check(tag, bad, 0);
  endtask

  initial begin
    int n;
    vectors = 0;
    fails   = 0;
    idle_in();
    rst = 1'b0;
    step();

    // 1: reset and power-up sweep
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_busy", {31'd0, busy}, 1);
    check("rst_valid", {30'd0, rd_valid}, 0);
    check("rst_data", {16'd0, rd_data}, 0);
    sweep("rst_sweep", n);
    read_all_zero("rst_allzero");

    // 2: write then read
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 8'hA5;
    step();
    wr_en = 1'b0;
    rd_en = 2'b01; rd_addr = {5'd0, 5'd7};
    step();
    check("rd7_data", {24'd0, rd_data[7:0]}, 32'hA5);
    check("rd7_valid", {30'd0, rd_valid}, 32'h1);

    // rd_en low: valid drops, data holds
    rd_en = 2'b00;
    step();
    check("hold_valid", {30'd0, rd_valid}, 0);
    check("hold_data", {24'd0, rd_data[7:0]}, 32'hA5);

    // 3: same-cycle write and read is bypassed
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 8'h3C;
    rd_en = 2'b10; rd_addr = {5'd3, 5'd0};
    step();
    wr_en = 1'b0;
    check("byp_data", {24'd0, rd_data[15:8]}, 32'h3C);
    check("byp_valid", {30'd0, rd_valid}, 32'h2);
    rd_en = 2'b11; rd_addr = {5'd3, 5'd3};
    step();
    check("byp_stored", {16'd0, rd_data}, 32'h3C3C);

    // 4: entry zero ignores writes, even under bypass
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 8'hFF;
    rd_en = 2'b00;
    step();
    rd_en = 2'b11; rd_addr = {5'd0, 5'd0};
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 8'hFF;
    step();
    check("zero_byp", {16'd0, rd_data}, 0);
    wr_en = 1'b0;
    step();
    check("zero_rd", {16'd0, rd_data}, 0);
    check("zero_valid", {30'd0, rd_valid}, 32'h3);
    rd_en = 2'b00;

    // 5: fill, then clear with writes attempted
    for (int a = 1; a < 32; a++) begin
      wr_en = 1'b1; wr_addr = 5'(a); wr_data = 8'(a);
      step();
    end
    wr_en = 1'b0;
    rd_en = 2'b11; rd_addr = {5'd31, 5'd9};
    step();
    check("fill_rd", {16'd0, rd_data}, 32'h1F09);
    rd_en = 2'b00;
    clear_req = 1'b1;
    wr_en = 1'b1; wr_addr = 5'd12; wr_data = 8'h77;
    step();
    clear_req = 1'b0;
    wr_addr = 5'd5; wr_data = 8'h55;
    check("clr_busy", {31'd0, busy}, 1);
    for (int i = 0; i < 10; i++) step();
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      step();
      n++;
    end
    wr_en = 1'b0;
    check("clr_len", n + 11, 32);
    read_all_zero("clr_allzero");

    // 6: reset mid-sweep restarts it
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    for (int i = 0; i < 10; i++) step();
    check("mid_busy", {31'd0, busy}, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    sweep("mid_sweep", n);
    wr_en = 1'b1; wr_addr = 5'd20; wr_data = 8'h5A;
    step();
    wr_en = 1'b0;
    rd_en = 2'b11; rd_addr = {5'd20, 5'd20};
    step();
    check("post_rd", {16'd0, rd_data}, 32'h5A5A);
    check("post_valid", {30'd0, rd_valid}, 32'h3);
    rd_en = 2'b00;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
